// File: rtl/sysid_checker.sv
// Boot-time system-ID consumer: reads the ID/timestamp pair SAMPLES times from the
// sysid slave, checks sample consistency and compares against build-time expectations.
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID  = 32'h7EE31387,
    parameter logic [31:0] EXPECTED_TS  = 32'h5CA1EC6A,
    parameter bit          CHECK_TS     = 1'b1,
    parameter int          READ_LATENCY = 1,
    parameter int          SAMPLES      = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic        sysid_address,
    output logic        sysid_read,
    input  logic [31:0] sysid_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_match,
    output logic        ts_match,
    output logic        unstable,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    // state  | meaning
    // IDLE   | waiting for start
    // ISSUE  | one-cycle read strobe for the current index
    // WAIT   | READ_LATENCY cycles, data captured on the last one
    // CHECK  | evaluate match flags and pass
    // DONE   | one-cycle completion pulse, may accept a new start
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY - 1);
    localparam logic [3:0] IDX_LAST = 4'(2 * SAMPLES - 1);

    state_t     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [1:0] lat_q, lat_d;
    logic       accept;
    logic       capture;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lat_d   = lat_q;
        accept  = 1'b0;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    idx_d   = 4'd0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                lat_d   = LAT_LAST;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (lat_q == 2'd0) begin
                    capture = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_CHECK;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = S_ISSUE;
                    end
                end else begin
                    lat_d = lat_q - 2'd1;
                end
            end
            S_CHECK: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    idx_d   = 4'd0;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            idx_q    <= 4'd0;
            lat_q    <= 2'd0;
            pass     <= 1'b0;
            id_match <= 1'b0;
            ts_match <= 1'b0;
            unstable <= 1'b0;
            id_value <= 32'd0;
            ts_value <= 32'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lat_q   <= lat_d;
            if (accept) begin
                pass     <= 1'b0;
                id_match <= 1'b0;
                ts_match <= 1'b0;
                unstable <= 1'b0;
            end
            // idx_q[0] selects the word, idx_q[3:1] the sample; only sample 0 is stored
            if (capture) begin
                if (idx_q[3:1] == 3'd0) begin
                    if (idx_q[0]) begin
                        ts_value <= sysid_readdata;
                    end else begin
                        id_value <= sysid_readdata;
                    end
                end else if (sysid_readdata != (idx_q[0] ? ts_value : id_value)) begin
                    unstable <= 1'b1;
                end
            end
            if (state_q == S_CHECK) begin
                id_match <= (id_value == EXPECTED_ID);
                ts_match <= (ts_value == EXPECTED_TS);
                pass     <= (id_value == EXPECTED_ID)
                          & ((ts_value == EXPECTED_TS) | !CHECK_TS)
                          & !unstable;
            end
        end
    end

    assign sysid_address = idx_q[0];
    assign sysid_read    = (state_q == S_ISSUE);
    assign busy          = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_CHECK);
    assign done          = (state_q == S_DONE);

endmodule
